fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  - IF stage of the pipelined LEGv8 processor, upstream of the IF/ID boundary and the datapath decode.
//  - Owns the PC and drives the imem address. Buffers fetched words and their PCs in a small FIFO.
//  - Lets decode stall without refetching; flushes on a taken branch from EX.
//  - Replaces the bare IF/ID instruction flop: delivers {instr, pc, valid} to decode.
// PARAMETERS
//  N        64  datapath/PC width
//  DEPTH    4   instruction queue entries (power of 2, >=2)
//  RESET_PC 0   PC value loaded on reset
// PORTS
//  clk          in   1   system clock (CLOCK_50 at top level)
//  reset        in   1   asynchronous, active-low reset (0 = reset asserted)
//  stall_D      in   1   decode cannot accept head this cycle
//  PCSrc        in   1   taken branch resolved in EX, flush request
//  PCBranch_E   in   N   branch target from EX
//  IM_addr      out  N   imem byte address (= PC)
//  IM_readData  in   32  imem word at IM_addr (combinational read)
//  instr_D      out  32  head instruction to decode
//  pc_D         out  N   PC of head instruction
//  valid_D      out  1   head entry valid
//  q_count      out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset: PC=RESET_PC, count=0, rd/wr ptrs=0, valid_D=0, instr_D=0, pc_D=0; IM_addr=RESET_PC.
//  - IM_addr = PC (combinational from PC register).
//  - push = (count<DEPTH) | pop. On push: entry[wr]={IM_readData,PC}; wr++; PC<=PC+4.
//  - pop = valid_D & ~stall_D. On pop: rd++.
//  - count' = count + push - pop. Both ptrs wrap modulo DEPTH.
//  - Outputs are combinational from the head entry: valid_D=(count!=0). instr_D/pc_D = entry[rd] when valid, else 0.
//  - Latency: a word fetched at edge t is visible on instr_D after edge t. Min 1-cycle fetch-to-decode, same as the old IF/ID flop.
//  - Full, no pop: no push, PC holds, IM_addr stable.
//  - Full with pop: push and pop in the same cycle, count stays DEPTH.
//  - Empty: no pop regardless of stall_D. Push fills the empty entry, valid_D=1 next cycle.
//  - Flush (PCSrc=1) overrides push/pop on that edge:
//    - count<=0, rd<=wr<=0, PC<={PCBranch_E[N-1:2],2'b00}.
//    - valid_D=0 in the following cycle; first target word is valid one cycle later.
//    - Wrong-path head is not consumed by the flush edge, even if stall_D=0.
//  - PCBranch_E[1:0] ignored (word-aligned).
//  - PC+4 wraps modulo 2^N, no trap.
//  - Reset asserted mid-operation: all state returns to reset values immediately (async). Release is sampled on the next clk edge.
//  - Single FSM over occupancy: EMPTY(count=0) -> FILL(0<count<DEPTH) -> FULL(count=DEPTH).
//    - Any state -> EMPTY on flush or reset.
//    - FULL -> FILL on pop without push. Push is blocked only when FULL and not popping.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs
//    - perf_fetch  (32b): total pushes
//    - perf_stall  (32b): cycles with valid_D & stall_D
//    - perf_flush  (32b): flush edges
//    - All three saturate at 2^32-1 and reset to 0.
//  FETCH_PERF_EN undefined: these ports and counters do not exist. Functional behaviour is identical.
// TESTING
//  - Reset, then release with stall_D=0, imem word i = i.
//    -> IM_addr 0,4,8,... Cycle after release: instr_D=0,pc_D=0,valid_D=1. Then pc_D increments by 4 each cycle, count stays 1.
//  - Hold stall_D=1 from reset release, DEPTH=4.
//    -> count reaches 4 after 4 edges. IM_addr frozen at 0x10. instr_D stays at pc 0.
//    -> Release stall: pc_D 0,4,8,C,10 on consecutive cycles, no gaps.
//  - Queue full and pop in the same cycle (stall_D pulsed low one cycle).
//    -> count stays 4, PC advances by 4, head moves to next PC.
//  - PCSrc=1 with PCBranch_E=0x103 while count=3.
//    -> next cycle valid_D=0, count=0, IM_addr=0x100. Following cycle instr_D=imem[0x100], pc_D=0x100.
//  - PCSrc=1 and stall_D=0 with valid head on the same edge.
//    -> head not counted as popped. Flush wins, queue empty.
//  - Assert reset low mid-fill (count=2).
//    -> valid_D=0, count=0, IM_addr=RESET_PC before the next clk edge.
//    -> With FETCH_PERF_EN: perf counters read 0.

Source files
------------

// File: rtl/fetch_queue_stage.sv
// rtl/fetch_queue_stage.sv - IF stage: PC, imem address and instruction queue feeding decode.
// Optional FETCH_PERF_EN adds saturating fetch/stall/flush counters.
module fetch_queue_stage #(
  parameter int             N        = 64,
  parameter int             DEPTH    = 4,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall_D,
  input  logic                       PCSrc,
  input  logic [N-1:0]               PCBranch_E,
  output logic [N-1:0]               IM_addr,
  input  logic [31:0]                IM_readData,
  output logic [31:0]                instr_D,
  output logic [N-1:0]               pc_D,
  output logic                       valid_D,
`ifdef FETCH_PERF_EN
  output logic [31:0]                perf_fetch,
  output logic [31:0]                perf_stall,
  output logic [31:0]                perf_flush,
`endif
  output logic [$clog2(DEPTH):0]     q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FULL} occ_state_t;

  occ_state_t     state;
  logic [N-1:0]   pc;
  logic [CW-1:0]  count;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [31:0]    mem_instr [DEPTH];
  logic [N-1:0]   mem_pc    [DEPTH];

  logic           push;
  logic           pop;
  logic           push_en;
  logic [CW-1:0]  count_next;

  assign valid_D = (state != S_EMPTY);
  assign pop     = valid_D & ~stall_D;
  assign push    = (state != S_FULL) | pop;
  assign push_en = push & ~PCSrc;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + ONE_C;
      2'b01:   count_next = count - ONE_C;
      default: count_next = count;
    endcase
  end

  // Flush takes priority over push/pop so the wrong-path head is simply dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_EMPTY;
      pc     <= RESET_PC;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (PCSrc) begin
      state  <= S_EMPTY;
      pc     <= {PCBranch_E[N-1:2], 2'b00};
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        pc     <= pc + N'(4);
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      case (state)
        S_EMPTY: if (push) state <= (count_next == DEPTH_C) ? S_FULL : S_FILL;
        S_FILL: begin
          if (count_next == '0)          state <= S_EMPTY;
          else if (count_next == DEPTH_C) state <= S_FULL;
        end
        S_FULL:  if (pop && !push) state <= S_FILL;
        default: state <= S_EMPTY;
      endcase
    end
  end

  // Queue storage needs no reset: outputs are masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_instr[wr_ptr] <= IM_readData;
      mem_pc[wr_ptr]    <= pc;
    end
  end

  assign IM_addr = pc;
  assign q_count = count;
  assign instr_D = valid_D ? mem_instr[rd_ptr] : 32'd0;
  assign pc_D    = valid_D ? mem_pc[rd_ptr]    : '0;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (push_en && perf_fetch != 32'hFFFF_FFFF)
        perf_fetch <= perf_fetch + 32'd1;
      if (valid_D && stall_D && perf_stall != 32'hFFFF_FFFF)
        perf_stall <= perf_stall + 32'd1;
      if (PCSrc && perf_flush != 32'hFFFF_FFFF)
        perf_flush <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// tb/tb_fetch_queue_stage.sv - directed bench for fetch_queue_stage.
// Imem model: word at byte address 4*i holds i.
module tb_fetch_queue_stage;

  localparam int N = 64;

  logic          clk;
  logic          reset;
  logic          stall_D;
  logic          PCSrc;
  logic [N-1:0]  PCBranch_E;
  logic [N-1:0]  IM_addr;
  logic [31:0]   IM_readData;
  logic [31:0]   instr_D;
  logic [N-1:0]  pc_D;
  logic          valid_D;
  logic [2:0]    q_count;
`ifdef FETCH_PERF_EN
  logic [31:0]   perf_fetch;
  logic [31:0]   perf_stall;
  logic [31:0]   perf_flush;
`endif

  int vectors = 0;
  int fails   = 0;

  fetch_queue_stage #(.N(N), .DEPTH(4), .RESET_PC('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall_D     (stall_D),
    .PCSrc       (PCSrc),
    .PCBranch_E  (PCBranch_E),
    .IM_addr     (IM_addr),
    .IM_readData (IM_readData),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .valid_D     (valid_D),
`ifdef FETCH_PERF_EN
    .perf_fetch  (perf_fetch),
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush),
`endif
    .q_count     (q_count)
  );

  assign IM_readData = IM_addr[33:2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    stall_D    = 1'b0;
    PCSrc      = 1'b0;
    PCBranch_E = '0;

    // Reset state
    tick(); tick();
    check("rst_valid", 64'(valid_D), 64'd0);
    check("rst_count", 64'(q_count), 64'd0);
    check("rst_addr",  IM_addr, 64'd0);
    check("rst_instr", 64'(instr_D), 64'd0);
    check("rst_pc",    pc_D, 64'd0);

    // Streaming with no stall
    reset = 1'b1;
    tick();
    check("s0_valid", 64'(valid_D), 64'd1);
    check("s0_instr", 64'(instr_D), 64'd0);
    check("s0_pc",    pc_D, 64'd0);
    check("s0_count", 64'(q_count), 64'd1);
    check("s0_addr",  IM_addr, 64'd4);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("s_pc",    pc_D, 64'(4 * i));
      check("s_instr", 64'(instr_D), 64'(i));
      check("s_count", 64'(q_count), 64'd1);
      check("s_addr",  IM_addr, 64'(4 * (i + 1)));
    end

    // Async reset, then fill under stall
    stall_D = 1'b1;
    reset   = 1'b0;
    #1;
    check("arst_valid", 64'(valid_D), 64'd0);
    check("arst_count", 64'(q_count), 64'd0);
    check("arst_addr",  IM_addr, 64'd0);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("fill_count", 64'(q_count), 64'(k));
    end
    check("full_addr",  IM_addr, 64'h10);
    check("full_instr", 64'(instr_D), 64'd0);
    check("full_pc",    pc_D, 64'd0);
    tick();
    check("full_hold_count", 64'(q_count), 64'd4);
    check("full_hold_addr",  IM_addr, 64'h10);

    // Full with a single-cycle pop
    stall_D = 1'b0;
    tick();
    check("fp_count", 64'(q_count), 64'd4);
    check("fp_pc",    pc_D, 64'h4);
    check("fp_instr", 64'(instr_D), 64'd1);
    check("fp_addr",  IM_addr, 64'h14);
    stall_D = 1'b1;
    tick();
    check("fp_hold_pc",   pc_D, 64'h4);
    check("fp_hold_addr", IM_addr, 64'h14);

    // Drain without gaps
    stall_D = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      tick();
      check("drain_pc",    pc_D, 64'(4 * i));
      check("drain_count", 64'(q_count), 64'd4);
    end
    check("drain_addr", IM_addr, 64'h20);

    // Flush with count=3 and unstalled valid head
    stall_D = 1'b1;
    reset   = 1'b0;
    #1;
    reset = 1'b1;
    tick(); tick(); tick();
    check("pre_flush_count", 64'(q_count), 64'd3);
    PCSrc      = 1'b1;
    PCBranch_E = 64'h103;
    stall_D    = 1'b0;
    tick();
    check("fl_valid", 64'(valid_D), 64'd0);
    check("fl_count", 64'(q_count), 64'd0);
    check("fl_addr",  IM_addr, 64'h100);
    check("fl_pc",    pc_D, 64'd0);
    check("fl_instr", 64'(instr_D), 64'd0);
    PCSrc = 1'b0;
    tick();
    check("tgt_valid", 64'(valid_D), 64'd1);
    check("tgt_pc",    pc_D, 64'h100);
    check("tgt_instr", 64'(instr_D), 64'h40);
    check("tgt_count", 64'(q_count), 64'd1);
    check("tgt_addr",  IM_addr, 64'h104);

    // Reset mid-fill at count=2
    stall_D = 1'b1;
    tick();
    check("mf_count", 64'(q_count), 64'd2);
    check("mf_pc",    pc_D, 64'h100);
    reset = 1'b0;
    #1;
    check("mf_rst_valid", 64'(valid_D), 64'd0);
    check("mf_rst_count", 64'(q_count), 64'd0);
    check("mf_rst_addr",  IM_addr, 64'd0);
`ifdef FETCH_PERF_EN
    check("mf_perf_fetch", 64'(perf_fetch), 64'd0);
    check("mf_perf_stall", 64'(perf_stall), 64'd0);
    check("mf_perf_flush", 64'(perf_flush), 64'd0);
`endif
    reset   = 1'b1;
    stall_D = 1'b0;

    // PC wrap and unaligned target
    tick();
    PCSrc      = 1'b1;
    PCBranch_E = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    check("wr_addr",  IM_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wr_valid", 64'(valid_D), 64'd0);
    PCSrc = 1'b0;
    tick();
    check("wr_pc",    pc_D, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wr_instr", 64'(instr_D), 64'hFFFF_FFFF);
    check("wr_next",  IM_addr, 64'd0);
    check("wr_vld",   64'(valid_D), 64'd1);
`ifdef FETCH_PERF_EN
    check("perf_fetch", 64'(perf_fetch), 64'd2);
    check("perf_stall", 64'(perf_stall), 64'd0);
    check("perf_flush", 64'(perf_flush), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
